// File: rtl/trigger_detector_pkg.sv
// Shared constants and state encoding for the trigger detector.
// Mode encoding matches the acquisition controller so the field can be passed straight through.
package trigger_detector_pkg;

    localparam logic [1:0] MODE_NORM      = 2'd0;
    localparam logic [1:0] MODE_AUTO      = 2'd1;
    localparam logic [1:0] MODE_IMMEDIATE = 2'd2;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        ARMED = 2'd2,
        FIRED = 2'd3
    } state_t;

    // Mode 3 is reserved and behaves like normal mode, so only these two need decoding.
    function automatic logic is_immediate(input logic [1:0] mode);
        return mode == MODE_IMMEDIATE;
    endfunction

    function automatic logic is_auto(input logic [1:0] mode);
        return mode == MODE_AUTO;
    endfunction

endpackage

// File: rtl/trigger_detector_if.sv
// Sample stream, configuration and trigger status between the controller and the detector.
// The controller side is the master; the detector is the slave.
interface trigger_detector_if #(
    parameter int DATA_W = 8,
    parameter int TMO_W  = 16
);
    logic [DATA_W-1:0] adc_data;
    logic              sample_en;
    logic              arm;
    logic [1:0]        mode;
    logic              slope;
    logic [DATA_W-1:0] level;
    logic [DATA_W-1:0] hyst;
    logic [TMO_W-1:0]  auto_timeout;
    logic              trigger_req;
    logic              armed;
    logic              forced;

    modport master (
        output adc_data, sample_en, arm, mode, slope, level, hyst, auto_timeout,
        input  trigger_req, armed, forced
    );

    modport slave (
        input  adc_data, sample_en, arm, mode, slope, level, hyst, auto_timeout,
        output trigger_req, armed, forced
    );

endinterface

// File: rtl/sync_counter.sv
// General-purpose up counter with synchronous clear and count enable.
// Clear takes priority over enable; wraps silently at the top of its range.
module sync_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/trigger_detector_threshold_cmp.sv
// Hysteresis thresholds and slope-dependent pre/fire compares for one sample.
// Purely combinational so a window trigger can later instantiate two of these.
module trigger_detector_threshold_cmp
    import trigger_detector_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] hyst,
    input  logic              slope,
    output logic              pre,
    output logic              fire
);

    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;

    // The extra bit carries the borrow/overflow used to clamp the band at the sample range ends.
    always_comb begin
        diff = {1'b0, level} - {1'b0, hyst};
        sum  = {1'b0, level} + {1'b0, hyst};
        lo   = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
        hi   = sum[DATA_W]  ? '1 : sum[DATA_W-1:0];
    end

    always_comb begin
        pre  = 1'b0;
        fire = 1'b0;
        if (slope == SLOPE_FALL) begin
            pre  = sample >= hi;
            fire = sample <= level;
        end else begin
            pre  = sample <= lo;
            fire = sample >= level;
        end
    end

endmodule

// File: rtl/trigger_detector.sv
// Level/auto/immediate trigger detector feeding the acquisition controller.
// Arms while the controller waits for a trigger and holds trigger_req until arm drops.
module trigger_detector
    import trigger_detector_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    trigger_detector_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic             forced_q;
    logic             forced_nxt;
    logic             pre;
    logic             fire;
    logic             cnt_clr;
    logic             cnt_en;
    logic [TMO_W-1:0] count;
    logic [TMO_W-1:0] tmo_last;
    logic             timeout_hit;
    logic             imm;

    trigger_detector_threshold_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .sample (bus.adc_data),
        .level  (bus.level),
        .hyst   (bus.hyst),
        .slope  (bus.slope),
        .pre    (pre),
        .fire   (fire)
    );

    sync_counter #(
        .WIDTH (TMO_W)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    // A zero timeout disables the auto trigger rather than firing on the first sample.
    assign tmo_last    = bus.auto_timeout - TMO_W'(1);
    assign timeout_hit = is_auto(bus.mode) && (bus.auto_timeout != '0) && (count == tmo_last);
    assign imm         = is_immediate(bus.mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            forced_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            forced_q <= forced_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        forced_nxt = forced_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        if (!bus.arm) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SEEK;
                    cnt_clr   = 1'b1;
                end
                // A real edge cannot fire here: the hysteresis pre-condition has not been seen yet.
                SEEK: begin
                    if (bus.sample_en) begin
                        cnt_en = 1'b1;
                        if (imm || timeout_hit) begin
                            state_nxt  = FIRED;
                            forced_nxt = 1'b1;
                        end else if (pre) begin
                            state_nxt = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (bus.sample_en) begin
                        cnt_en = 1'b1;
                        if (fire) begin
                            state_nxt  = FIRED;
                            forced_nxt = 1'b0;
                        end else if (imm || timeout_hit) begin
                            state_nxt  = FIRED;
                            forced_nxt = 1'b1;
                        end
                    end
                end
                FIRED: begin
                    state_nxt = FIRED;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.trigger_req = (state == FIRED);
    assign bus.armed       = (state == ARMED);
    assign bus.forced      = forced_q;

endmodule

// File: tb/tb_trigger_detector.sv
// Self-checking bench for trigger_detector: directed vector table, reset corner cases,
// then randomized traffic against a flag-based reference model.
module tb_trigger_detector;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    trigger_detector_if #(.DATA_W(8), .TMO_W(16)) bus ();

    trigger_detector #(
        .DATA_W (8),
        .TMO_W  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        arm;
        logic        se;
        logic [1:0]  mode;
        logic        slope;
        logic [7:0]  level;
        logic [7:0]  hyst;
        logic [15:0] tmo;
        logic [7:0]  adc;
        logic [2:0]  exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model: waiting flag, pre-condition seen, request held, forced origin, samples seen.
    bit m_active;
    bit m_primed;
    bit m_fired;
    bit m_forced;
    int m_count;

    function automatic vec_t mk(string name, logic a, logic se, logic [1:0] m, logic sl,
                                int lv, int hy, int tmo, int adc, logic [2:0] exp);
        vec_t v;
        v.name  = name;
        v.arm   = a;
        v.se    = se;
        v.mode  = m;
        v.slope = sl;
        v.level = 8'(lv);
        v.hyst  = 8'(hy);
        v.tmo   = 16'(tmo);
        v.adc   = 8'(adc);
        v.exp   = exp;
        return v;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_primed = 0;
        m_fired  = 0;
        m_forced = 0;
        m_count  = 0;
    endtask

    task automatic model_step();
        int lv, hy, s, lo, hi, tmo;
        bit pre, fire, timeout;
        lv  = int'(bus.level);
        hy  = int'(bus.hyst);
        s   = int'(bus.adc_data);
        tmo = int'(bus.auto_timeout);
        lo  = (lv - hy < 0) ? 0 : lv - hy;
        hi  = (lv + hy > 255) ? 255 : lv + hy;
        if (bus.slope) begin
            pre  = s >= hi;
            fire = s <= lv;
        end else begin
            pre  = s <= lo;
            fire = s >= lv;
        end
        timeout = (bus.mode == 2'd1) && (tmo != 0) && ((m_count % 65536) == tmo - 1);
        if (!bus.arm) begin
            m_active = 0;
            m_primed = 0;
            m_fired  = 0;
            m_count  = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_count  = 0;
        end else if (!m_fired && bus.sample_en) begin
            if (m_primed && fire) begin
                m_fired  = 1;
                m_forced = 0;
            end else if (bus.mode == 2'd2 || timeout) begin
                m_fired  = 1;
                m_forced = 1;
            end else if (!m_primed && pre) begin
                m_primed = 1;
            end
            m_count++;
        end
    endtask

    function automatic logic [2:0] model_outputs();
        return {m_fired, m_primed && !m_fired, m_forced};
    endfunction

    task automatic apply_stimulus(input logic a, input logic se, input logic [1:0] m,
                                  input logic sl, input logic [7:0] lv, input logic [7:0] hy,
                                  input logic [15:0] tmo, input logic [7:0] adc);
        bus.arm          = a;
        bus.sample_en    = se;
        bus.mode         = m;
        bus.slope        = sl;
        bus.level        = lv;
        bus.hyst         = hy;
        bus.auto_timeout = tmo;
        bus.adc_data     = adc;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [2:0] exp);
        logic [2:0] act;
        act = {bus.trigger_req, bus.armed, bus.forced};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: req/armed/forced got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    initial begin
        int lv, hy, tmo, off;
        logic [1:0] md;
        logic sl;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        apply_stimulus(0, 0, 2'd0, 0, 8'd0, 8'd0, 16'd0, 8'd0);
        model_reset();
        check_output("reset_state", 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rising edge, level 128 hyst 10 -> lo 118
        tbl.push_back(mk("rise_idle",     0, 0, 0, 0, 128, 10, 0, 0,   3'b000));
        tbl.push_back(mk("rise_seek",     1, 0, 0, 0, 128, 10, 0, 0,   3'b000));
        tbl.push_back(mk("rise_200",      1, 1, 0, 0, 128, 10, 0, 200, 3'b000));
        tbl.push_back(mk("rise_115_arm",  1, 1, 0, 0, 128, 10, 0, 115, 3'b010));
        tbl.push_back(mk("rise_127",      1, 1, 0, 0, 128, 10, 0, 127, 3'b010));
        tbl.push_back(mk("rise_128_fire", 1, 1, 0, 0, 128, 10, 0, 128, 3'b100));
        tbl.push_back(mk("rise_disarm",   0, 0, 0, 0, 128, 10, 0, 0,   3'b000));
        // Falling edge, level 100 hyst 20 -> hi 120
        tbl.push_back(mk("fall_seek",     1, 0, 0, 1, 100, 20, 0, 0,   3'b000));
        tbl.push_back(mk("fall_119_none", 1, 1, 0, 1, 100, 20, 0, 119, 3'b000));
        tbl.push_back(mk("fall_110",      1, 1, 0, 1, 100, 20, 0, 110, 3'b000));
        tbl.push_back(mk("fall_121_arm",  1, 1, 0, 1, 100, 20, 0, 121, 3'b010));
        tbl.push_back(mk("fall_100_fire", 1, 1, 0, 1, 100, 20, 0, 100, 3'b100));
        tbl.push_back(mk("fall_disarm",   0, 0, 0, 1, 100, 20, 0, 0,   3'b000));
        // Saturated low threshold: level 5 hyst 10 -> lo 0
        tbl.push_back(mk("satlo_seek",    1, 0, 0, 0, 5, 10, 0, 0, 3'b000));
        tbl.push_back(mk("satlo_1",       1, 1, 0, 0, 5, 10, 0, 1, 3'b000));
        tbl.push_back(mk("satlo_0_arm",   1, 1, 0, 0, 5, 10, 0, 0, 3'b010));
        tbl.push_back(mk("satlo_5_fire",  1, 1, 0, 0, 5, 10, 0, 5, 3'b100));
        tbl.push_back(mk("satlo_disarm",  0, 0, 0, 0, 5, 10, 0, 0, 3'b000));
        // Saturated high threshold: level 250 hyst 10 -> hi 255
        tbl.push_back(mk("sathi_seek",    1, 0, 0, 1, 250, 10, 0, 0,   3'b000));
        tbl.push_back(mk("sathi_254",     1, 1, 0, 1, 250, 10, 0, 254, 3'b000));
        tbl.push_back(mk("sathi_255_arm", 1, 1, 0, 1, 250, 10, 0, 255, 3'b010));
        tbl.push_back(mk("sathi_fire",    1, 1, 0, 1, 250, 10, 0, 250, 3'b100));
        tbl.push_back(mk("sathi_disarm",  0, 0, 0, 1, 250, 10, 0, 0,   3'b000));
        // Auto timeout 4, flat 50 (arms on first sample, times out on the fourth)
        tbl.push_back(mk("auto_seek",     1, 0, 1, 0, 128, 10, 4, 50, 3'b000));
        tbl.push_back(mk("auto_s1",       1, 1, 1, 0, 128, 10, 4, 50, 3'b010));
        tbl.push_back(mk("auto_s2",       1, 1, 1, 0, 128, 10, 4, 50, 3'b010));
        tbl.push_back(mk("auto_s3",       1, 1, 1, 0, 128, 10, 4, 50, 3'b010));
        tbl.push_back(mk("auto_s4_tmo",   1, 1, 1, 0, 128, 10, 4, 50, 3'b101));
        tbl.push_back(mk("auto_hold",     1, 1, 1, 0, 128, 10, 4, 50, 3'b101));
        tbl.push_back(mk("auto_disarm",   0, 0, 1, 0, 128, 10, 4, 50, 3'b001));
        // Auto timeout 4 with a real crossing on the fourth sample
        tbl.push_back(mk("autor_seek",    1, 0, 1, 0, 128, 10, 4, 50,  3'b001));
        tbl.push_back(mk("autor_s1",      1, 1, 1, 0, 128, 10, 4, 50,  3'b011));
        tbl.push_back(mk("autor_s2",      1, 1, 1, 0, 128, 10, 4, 50,  3'b011));
        tbl.push_back(mk("autor_s3",      1, 1, 1, 0, 128, 10, 4, 50,  3'b011));
        tbl.push_back(mk("autor_s4_real", 1, 1, 1, 0, 128, 10, 4, 200, 3'b100));
        tbl.push_back(mk("autor_disarm",  0, 0, 1, 0, 128, 10, 4, 0,   3'b000));
        // Immediate mode
        tbl.push_back(mk("imm_seek",      1, 0, 2, 0, 128, 10, 0, 200, 3'b000));
        tbl.push_back(mk("imm_no_sample", 1, 0, 2, 0, 128, 10, 0, 200, 3'b000));
        tbl.push_back(mk("imm_fire",      1, 1, 2, 0, 128, 10, 0, 200, 3'b101));
        tbl.push_back(mk("imm_disarm",    0, 0, 2, 0, 128, 10, 0, 200, 3'b001));
        // sample_en low must freeze ARMED even with a firing value present
        tbl.push_back(mk("hold_seek",     1, 0, 0, 0, 128, 10, 0, 0,   3'b001));
        tbl.push_back(mk("hold_arm",      1, 1, 0, 0, 128, 10, 0, 100, 3'b011));
        tbl.push_back(mk("hold_no_se",    1, 0, 0, 0, 128, 10, 0, 200, 3'b011));
        tbl.push_back(mk("hold_fire",     1, 1, 0, 0, 128, 10, 0, 200, 3'b100));
        tbl.push_back(mk("hold_disarm",   0, 0, 0, 0, 128, 10, 0, 0,   3'b000));

        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].arm, tbl[i].se, tbl[i].mode, tbl[i].slope, tbl[i].level,
                           tbl[i].hyst, tbl[i].tmo, tbl[i].adc);
            check_output(tbl[i].name, tbl[i].exp);
        end

        // Reset while ARMED with forced still set from an earlier immediate trigger
        apply_stimulus(1, 0, 2, 0, 128, 10, 0, 200);
        apply_stimulus(1, 1, 2, 0, 128, 10, 0, 200);
        apply_stimulus(0, 0, 0, 0, 128, 10, 0, 200);
        apply_stimulus(1, 0, 0, 0, 128, 10, 0, 100);
        apply_stimulus(1, 1, 0, 0, 128, 10, 0, 100);
        check_output("pre_reset_armed", 3'b011);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("reset_async_armed", 3'b000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1, 1, 0, 0, 128, 10, 0, 140);
        check_output("post_reset_seek", 3'b000);
        apply_stimulus(1, 1, 0, 0, 128, 10, 0, 140);
        check_output("no_fire_without_rearm", 3'b000);
        apply_stimulus(1, 1, 0, 0, 128, 10, 0, 118);
        check_output("rearm_118", 3'b010);
        apply_stimulus(1, 1, 0, 0, 128, 10, 0, 140);
        check_output("rearmed_fire", 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("reset_async_fired", 3'b000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        lv  = 128;
        hy  = 10;
        tmo = 4;
        md  = 2'd0;
        sl  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                apply_stimulus(0, 1'($urandom_range(0, 1)), md, sl, 8'(lv), 8'(hy), 16'(tmo), 8'($urandom));
                md  = 2'($urandom_range(0, 3));
                sl  = 1'($urandom_range(0, 1));
                tmo = $urandom_range(0, 8);
                hy  = $urandom_range(0, 40);
                lv  = $urandom_range(0, 255);
            end else begin
                if ($urandom_range(0, 99) == 0) lv = $urandom_range(0, 255);
                off = int'($urandom_range(0, 120)) - 60;
                off = lv + off;
                if (off < 0) off = 0;
                if (off > 255) off = 255;
                apply_stimulus(1, 1'($urandom_range(0, 1)), md, sl, 8'(lv), 8'(hy), 16'(tmo), 8'(off));
            end
            check_output("random", model_outputs());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trigger_detector.md
Name: trigger_detector

Overview:
- Upstream neighbour of the acquisition controller.
- Watches the raw ADC sample stream at the controller's sample strobe and raises trigger_req when the configured condition is met: level crossing with hysteresis and slope select, auto-timeout, or immediate.
- Arms only while the controller reports waiting_for_trigger; holds the request until the controller leaves that state.

Parameters:
- DATA_W, 8, ADC sample width (unsigned).
- TMO_W, 16, width of auto-mode timeout counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- adc_data  in  DATA_W  raw ADC sample; valid in cycles where sample_en=1.
- sample_en  in  1  sample strobe, driven by controller mem_en.
- arm  in  1  controller waiting_for_trigger.
- mode  in  2  0=normal, 1=auto, 2=immediate, 3=treated as normal.
- slope  in  1  0=rising, 1=falling.
- level  in  DATA_W  trigger threshold.
- hyst  in  DATA_W  hysteresis band.
- auto_timeout  in  TMO_W  samples to wait in auto mode before forced trigger.
- trigger_req  out  1  registered trigger request to controller.
- armed  out  1  status: hysteresis pre-condition satisfied, edge now fires.
- forced  out  1  status: last trigger came from timeout or immediate, not a real edge.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - trigger_req=0, armed=0, forced=0.
  - Timeout counter=0.
- Thresholds (combinational from level and hyst):
  - lo = level-hyst, saturating at 0.
  - hi = level+hyst, saturating at 2^DATA_W-1.
  - Compute at DATA_W+1 bits, then clamp.
- Pre/fire conditions, evaluated only when sample_en=1:
  - Rising: pre = adc_data<=lo; fire = adc_data>=level.
  - Falling: pre = adc_data>=hi; fire = adc_data<=level.
- States:
  - IDLE:
    - arm=1 -> SEEK.
    - Counter cleared.
  - SEEK:
    - arm=0 -> IDLE.
    - mode=2 with sample_en -> FIRED (forced=1).
    - Else if sample_en and pre -> ARMED.
  - ARMED:
    - arm=0 -> IDLE.
    - sample_en and fire -> FIRED (forced=0).
    - mode=2 with sample_en -> FIRED (forced=1).
  - FIRED:
    - trigger_req=1.
    - Stays until arm=0, then -> IDLE.
- Auto mode:
  - In SEEK/ARMED, the counter increments on each sample_en.
  - When counter==auto_timeout-1 and sample_en, and no real fire occurs that same sample -> FIRED with forced=1.
  - auto_timeout=0 means never time out.
- Priority for the same sample: real fire > immediate > timeout.
  - A real fire in SEEK is impossible; pre must be seen first.
  - A single sample cannot both arm and fire.
- Latency: trigger_req rises 1 clk after the sample_en cycle carrying the qualifying sample.
- Outputs:
  - trigger_req is registered, asserted iff state==FIRED.
  - armed is asserted iff state==ARMED.
  - forced is updated on entry to FIRED and holds until the next FIRED entry.
- Config is sampled live, not latched; changing level, slope or mode mid-acquisition takes effect on the next sample_en.
- arm dropping in any state: return to IDLE next clk, clear the counter, deassert trigger_req.
- sample_en=0 cycles: no state or counter change except arm-driven transitions.
- rst_n asserted mid-operation: immediate return to reset values; trigger_req drops asynchronously.

Decomposition:
- Shared package holds:
  - Mode constants MODE_NORM=0, MODE_AUTO=1, MODE_IMMEDIATE=2 (same encoding as controller).
  - Slope constants SLOPE_RISE=0, SLOPE_FALL=1.
  - State encoding IDLE/SEEK/ARMED/FIRED (2 bits).
- One sub-module: threshold_cmp.
  - Combinational saturating lo/hi computation plus pre/fire compare.
  - Keeps the FSM file clean and is reusable for a future window trigger.
- Timeout counter uses the existing sync-reset/enable counter block.

Test Plan:
- Rising, DATA_W=8, level=128, hyst=10, mode=0, arm=1; samples 200,115,127,128 -> armed after 115; trigger_req=1 one clk after the 128 sample; forced=0.
- Falling, level=100, hyst=20, mode=0; samples 110,121,100 -> arm on 121, fire on 100; sample 119 alone must never arm.
- Saturation: level=5, hyst=10, rising -> lo=0; sample 0 arms, sample 5 fires. Also level=250, hyst=10, falling -> hi=255; sample 255 arms.
- Auto, auto_timeout=4, flat input 50, level=128 -> trigger_req after 4th sample_en, forced=1. Repeat with a real crossing on the 4th sample -> forced=0.
- Immediate, mode=2, arm rises -> trigger_req 1 clk after the first sample_en following SEEK entry; arm drops -> trigger_req=0 next clk, state IDLE.
- Reset mid-ARMED: rst_n low -> trigger_req/armed/forced=0 immediately. After release with arm=1, rising sample 140 must not fire until a sample <=118 re-arms.
